// File: rtl/counter_seq_pkg.sv
// Shared types and default sizes for the up/down counter sequencer.
package counter_seq_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STEP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } counter_seq_state_t;

endpackage

// File: rtl/updown_count_core.sv
// Count register with load, wrapping increment and saturating decrement.
module updown_count_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             underflow_evt
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (inc) begin
      count_d = count_q + WIDTH'(1);
    end else if (dec) begin
      count_d = (count_q == '0) ? '0 : count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A decrement request at zero is reported so the sequencer can latch it.
  assign underflow_evt = dec && !load && !inc && (count_q == '0);
  assign count         = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// Runs one up phase then one down phase on the count core per accepted start.
//   state   | meaning
//   IDLE    | waiting for start; count and underflow hold
//   UP      | increment once per cycle until up_rem is exhausted
//   DOWN    | decrement (saturating) until dn_rem is exhausted
//   DONE    | one-cycle completion pulse, then back to IDLE
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STEP_W = DEFAULT_STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  start_value,
  input  logic [STEP_W-1:0] up_steps,
  input  logic [STEP_W-1:0] down_steps,
  output logic              busy,
  output logic              done,
  output logic              underflow,
  output logic [WIDTH-1:0]  count
);

  counter_seq_state_t state_q, state_d;
  logic [STEP_W-1:0]  up_rem_q, up_rem_d;
  logic [STEP_W-1:0]  dn_rem_q, dn_rem_d;
  logic               underflow_q, underflow_d;
  logic               core_load, core_inc, core_dec, underflow_evt;

  always_comb begin
    state_d   = state_q;
    up_rem_d  = up_rem_q;
    dn_rem_d  = dn_rem_q;
    core_load = 1'b0;
    core_inc  = 1'b0;
    core_dec  = 1'b0;
    // Abort wins over everything, including a start seen in IDLE.
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            core_load = 1'b1;
            up_rem_d  = up_steps;
            dn_rem_d  = down_steps;
            state_d   = ST_UP;
          end
        end
        ST_UP: begin
          if (up_rem_q != '0) begin
            core_inc = 1'b1;
            up_rem_d = up_rem_q - STEP_W'(1);
          end else begin
            state_d = ST_DOWN;
          end
        end
        ST_DOWN: begin
          if (dn_rem_q != '0) begin
            core_dec = 1'b1;
            dn_rem_d = dn_rem_q - STEP_W'(1);
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    underflow_d = underflow_q | underflow_evt;
    if (core_load) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      up_rem_q    <= '0;
      dn_rem_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      up_rem_q    <= up_rem_d;
      dn_rem_q    <= dn_rem_d;
      underflow_q <= underflow_d;
    end
  end

  updown_count_core #(.WIDTH(WIDTH)) u_core (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (core_load),
    .load_value    (start_value),
    .inc           (core_inc),
    .dec           (core_dec),
    .count         (count),
    .underflow_evt (underflow_evt)
  );

  assign busy      = (state_q == ST_UP) || (state_q == ST_DOWN);
  assign done      = (state_q == ST_DONE);
  assign underflow = underflow_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench: directed vector table, corner-case sequences and random runs vs. an arithmetic model.
module tb_counter_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] start_value;
  logic [7:0] up_steps;
  logic [7:0] down_steps;
  logic       busy;
  logic       done;
  logic       underflow;
  logic [7:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  counter_sequencer #(.WIDTH(8), .STEP_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .start_value (start_value),
    .up_steps    (up_steps),
    .down_steps  (down_steps),
    .busy        (busy),
    .done        (done),
    .underflow   (underflow),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sv;
    int up;
    int dn;
    bit mid_start;
    int exp_count;
    int exp_uf;
    int exp_lat;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: wrap on the way up, clamp at zero on the way down.
  function automatic void model(input int sv, input int u, input int d,
                                output int c, output int uf, output int lat);
    int peak;
    peak = (sv + u) % 256;
    uf   = (d > peak) ? 1 : 0;
    c    = (d > peak) ? 0 : peak - d;
    lat  = u + d + 2;
  endfunction

  task automatic run_seq(input int sv, input int u, input int d, input bit mid_start,
                         output int c, output int uf, output int lat,
                         output int busy_n, output int done_ok);
    c = -1; uf = -1; lat = -1; busy_n = 0; done_ok = 0;
    @(negedge clk);
    start = 1'b1;
    start_value = 8'(sv);
    up_steps = 8'(u);
    down_steps = 8'(d);
    @(negedge clk);
    start = 1'b0;
    start_value = 8'($urandom);
    up_steps = 8'($urandom);
    down_steps = 8'($urandom);
    for (int k = 0; k < 700; k++) begin
      if (mid_start && k == 1) start = 1'b1;
      if (k == 2) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        lat = k;
        c = int'(count);
        uf = int'(underflow);
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (lat >= 0) begin
      @(negedge clk);
      done_ok = (!done && !busy) ? 1 : 0;
    end
  endtask

  task automatic do_vec(input string tag, input vec_t v);
    int c, uf, lat, bn, dok;
    run_seq(v.sv, v.up, v.dn, v.mid_start, c, uf, lat, bn, dok);
    check({tag, " count"}, c, v.exp_count);
    check({tag, " underflow"}, uf, v.exp_uf);
    check({tag, " done latency"}, lat, v.exp_lat);
    check({tag, " busy cycles"}, bn, v.up + v.dn + 2);
    check({tag, " done one cycle"}, dok, 1);
  endtask

  vec_t vecs[8];

  initial begin
    int c, uf, lat, bn, dok;
    vec_t v;

    vecs[0] = '{sv: 'h10, up: 5, dn: 3, mid_start: 0, exp_count: 'h12, exp_uf: 0, exp_lat: 10};
    vecs[1] = '{sv: 'hFE, up: 3, dn: 0, mid_start: 0, exp_count: 'h01, exp_uf: 0, exp_lat: 5};
    vecs[2] = '{sv: 'h02, up: 0, dn: 5, mid_start: 0, exp_count: 'h00, exp_uf: 1, exp_lat: 7};
    vecs[3] = '{sv: 'hAA, up: 0, dn: 0, mid_start: 0, exp_count: 'hAA, exp_uf: 0, exp_lat: 2};
    vecs[4] = '{sv: 'h10, up: 5, dn: 3, mid_start: 1, exp_count: 'h12, exp_uf: 0, exp_lat: 10};
    vecs[5] = '{sv: 'h05, up: 2, dn: 7, mid_start: 0, exp_count: 'h00, exp_uf: 0, exp_lat: 11};
    vecs[6] = '{sv: 'h05, up: 2, dn: 8, mid_start: 0, exp_count: 'h00, exp_uf: 1, exp_lat: 12};
    vecs[7] = '{sv: 'h00, up: 0, dn: 1, mid_start: 1, exp_count: 'h00, exp_uf: 1, exp_lat: 3};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    start_value = 8'h00; up_steps = 8'h00; down_steps = 8'h00;
    #12;
    check("reset count", int'(count), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset underflow", int'(underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) do_vec($sformatf("vec%0d", i), vecs[i]);

    // Underflow is sticky in IDLE until the next accept.
    repeat (3) @(negedge clk);
    check("idle underflow held", int'(underflow), 1);

    // Abort in UP at count 0x13.
    @(negedge clk);
    start = 1'b1; start_value = 8'h10; up_steps = 8'd10; down_steps = 8'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-abort count", int'(count), 'h13);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort count", int'(count), 'h13);
    check("abort underflow", int'(underflow), 0);
    begin
      int saw_done = 0;
      for (int k = 0; k < 15; k++) begin
        @(negedge clk);
        if (done || busy) saw_done = 1;
      end
      check("abort no done", saw_done, 0);
    end

    // start with abort in IDLE: no load, stays idle.
    start = 1'b1; abort = 1'b1; start_value = 8'h55;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start+abort busy", int'(busy), 0);
    check("start+abort count", int'(count), 'h13);

    // Asynchronous reset mid-sequence.
    @(negedge clk);
    start = 1'b1; start_value = 8'h40; up_steps = 8'd9; down_steps = 8'd60;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst count", int'(count), 0);
    check("async rst busy", int'(busy), 0);
    check("async rst done", int'(done), 0);
    check("async rst underflow", int'(underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_vec("post-reset", vecs[0]);

    // Randomized sequences against the arithmetic model.
    for (int i = 0; i < 25; i++) begin
      v.sv = int'($urandom_range(0, 255));
      v.up = int'($urandom_range(0, 20));
      v.dn = int'($urandom_range(0, 40));
      v.mid_start = 1'($urandom_range(0, 1));
      model(v.sv, v.up, v.dn, v.exp_count, v.exp_uf, v.exp_lat);
      do_vec($sformatf("rand%0d", i), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
